// File: rtl/uart_bus_initiator.sv
// Autonomous HB-bus initiator for the UART register map: polls status, drains RX
// bytes onto a valid/ready stream and pushes TX stream bytes into the TX FIFO.
module uart_bus_initiator #(
  parameter int ADDR_W   = 2,
  parameter int POLL_GAP = 4
) (
  input  logic              hb_clk,
  input  logic              rst,
  output logic              ren,
  output logic [ADDR_W-1:0] raddr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  input  logic [7:0]        tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [7:0]        rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              tx_drained
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [2:0] {
    S_POLL, S_STATUS, S_RD_RX, S_RD_WAIT, S_WR_TX, S_GAP
  } state_e;

  state_e              state_q, state_d;
  logic                last_rx_q, last_rx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                ren_q, ren_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                wen_q, wen_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                tx_ready_q, tx_ready_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                drained_q, drained_d;
  logic                rx_ok, tx_ok;
  logic                unused_rdata;

  assign unused_rdata = ^rdata[31:8];

  always_comb begin
    state_d    = state_q;
    last_rx_d  = last_rx_q;
    gap_d      = gap_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    drained_d  = drained_q;
    rx_ok      = 1'b0;
    tx_ok      = 1'b0;
    case (state_q)
      // Out of reset the strobe register is still 0, so spend one cycle arming it.
      S_POLL:    if (ren_q) state_d = S_STATUS;
      S_STATUS: begin
        drained_d = rdata[2];
        rx_ok     = rdata[1] && (!rx_valid_q || rx_ready);
        tx_ok     = rdata[0] && tx_valid;
        if (rx_ok && (!tx_ok || !last_rx_q)) begin
          state_d = S_RD_RX;
        end else if (tx_ok) begin
          state_d = S_WR_TX;
        end else if (POLL_GAP == 0) begin
          state_d = S_POLL;
        end else begin
          state_d = S_GAP;
          gap_d   = '0;
        end
      end
      S_RD_RX:   state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        rx_data_d  = rdata[7:0];
        rx_valid_d = 1'b1;
        last_rx_d  = 1'b1;
        state_d    = S_POLL;
      end
      S_WR_TX: begin
        last_rx_d = 1'b0;
        state_d   = S_POLL;
      end
      S_GAP: begin
        if (int'(gap_q) >= POLL_GAP - 1) state_d = S_POLL;
        else                             gap_d   = gap_q + 1'b1;
      end
      default:   state_d = S_POLL;
    endcase

    // Bus strobes are registered copies of the state being entered.
    ren_d      = (state_d == S_POLL) || (state_d == S_RD_RX);
    raddr_d    = (state_d == S_POLL) ? ADDR_W'(1) : '0;
    wen_d      = (state_d == S_WR_TX);
    tx_ready_d = (state_d == S_WR_TX);
    wdata_d    = (state_d == S_WR_TX) ? {24'b0, tx_data} : '0;
  end

  always_ff @(posedge hb_clk) begin
    if (rst) begin
      state_q    <= S_POLL;
      last_rx_q  <= 1'b0;
      gap_q      <= '0;
      ren_q      <= 1'b0;
      raddr_q    <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      tx_ready_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_rx_q  <= last_rx_d;
      gap_q      <= gap_d;
      ren_q      <= ren_d;
      raddr_q    <= raddr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      tx_ready_q <= tx_ready_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      drained_q  <= drained_d;
    end
  end

  assign ren        = ren_q;
  assign raddr      = raddr_q;
  assign wen        = wen_q;
  assign waddr      = '0;
  assign wdata      = wdata_q;
  assign tx_ready   = tx_ready_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_drained = drained_q;

endmodule

// File: tb/tb_uart_bus_initiator.sv
// Scoreboard bench for uart_bus_initiator with a behavioural UART slave model.
module tb_uart_bus_initiator;

  localparam logic [7:0] ACC_R = 8'h52;
  localparam logic [7:0] ACC_W = 8'h57;

  logic        hb_clk = 1'b0;
  logic        rst;
  logic        ren, wen, tx_ready, rx_valid, tx_drained;
  logic [1:0]  raddr, waddr;
  logic [31:0] wdata;
  logic [31:0] rdata = '0;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid;
  logic        rx_ready;
  logic [3:0]  stat;

  logic [7:0]  rxq[$];
  logic [7:0]  tx_src[$];
  logic [7:0]  exp_rx[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  acc_log[$];
  bit          log_en = 1'b0;
  bit          tx_hs;
  int          n_cmp = 0, n_fail = 0;
  int          cyc = 0, last_poll = 0, n_rd = 0, n_wr = 0;

  uart_bus_initiator #(.ADDR_W(2), .POLL_GAP(4)) dut (
    .hb_clk(hb_clk), .rst(rst), .ren(ren), .raddr(raddr), .wen(wen),
    .waddr(waddr), .wdata(wdata), .rdata(rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .tx_drained(tx_drained)
  );

  always #5 hb_clk = ~hb_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", nm, act, $time);
  endtask

  // kind: 0 status poll, 1 RX data read, 2 TX write, 3 rx_valid high
  task automatic wait_ev(input int kind, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge hb_clk); #1;
      case (kind)
        0:       hit = ren && (raddr == 2'd1);
        1:       hit = ren && (raddr == 2'd0);
        2:       hit = wen;
        default: hit = rx_valid;
      endcase
      if (hit) break;
    end
    check(nm, {31'b0, hit}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge hb_clk); #1; end
  endtask

  // UART slave: read data is returned the cycle after ren.
  always @(posedge hb_clk) begin
    logic [7:0] b;
    if (ren) begin
      if (raddr == 2'd1) begin
        rdata <= {28'b0, stat[3], stat[2], stat[1] && (rxq.size() != 0), stat[0]};
      end else if (rxq.size() != 0) begin
        b = rxq.pop_front();
        rdata <= {24'b0, b};
      end else begin
        rdata <= 32'h0;
      end
    end
  end

  // TX byte source: holds each byte until the handshake, then offers the next.
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge hb_clk);
      tx_hs = tx_valid && tx_ready;
      @(posedge hb_clk);
      #1;
      if (tx_hs || !tx_valid) begin
        if (tx_src.size() != 0) begin
          tx_data  = tx_src.pop_front();
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a byte or a write.
  always @(negedge hb_clk) begin
    logic [7:0] e;
    cyc++;
    if (!rst) begin
      if (ren && raddr == 2'd1) last_poll = cyc;
      if (ren && raddr == 2'd0) begin
        n_rd++;
        if (log_en) acc_log.push_back(ACC_R);
      end
      if (wen) begin
        n_wr++;
        if (log_en) acc_log.push_back(ACC_W);
        check("ren_wen_exclusive", {31'b0, ren}, 32'd0);
        check("waddr", {30'b0, waddr}, 32'd0);
        if (exp_tx.size() == 0) fail_now("tx_write_unexpected", wdata);
        else begin
          e = exp_tx.pop_front();
          check("wdata", wdata, {24'b0, e});
        end
      end
      if (wen || tx_ready) check("tx_ready_with_wen", {31'b0, tx_ready}, {31'b0, wen});
      if (rx_valid && rx_ready) begin
        if (exp_rx.size() == 0) fail_now("rx_byte_unexpected", {24'b0, rx_data});
        else begin
          e = exp_rx.pop_front();
          check("rx_data", {24'b0, rx_data}, {24'b0, e});
        end
      end
    end
  end

  initial begin
    int prev, p, r0, w0;
    logic [7:0] exp_seq [6];
    exp_seq = '{ACC_R, ACC_W, ACC_R, ACC_W, ACC_R, ACC_W};
    rst = 1'b1;
    rx_ready = 1'b0;
    stat = 4'b0101;

    // Test 1: reset values, then idle polling every POLL_GAP+2 cycles
    repeat (3) @(posedge hb_clk);
    @(negedge hb_clk); #1;
    check("rst_ren", {31'b0, ren}, 32'd0);
    check("rst_wen", {31'b0, wen}, 32'd0);
    check("rst_raddr", {30'b0, raddr}, 32'd0);
    check("rst_waddr", {30'b0, waddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("rst_tx_drained", {31'b0, tx_drained}, 32'd0);
    @(posedge hb_clk); #1;
    rst = 1'b0;
    wait_ev(0, "first_poll");
    prev = cyc;
    for (int i = 0; i < 24; i++) begin
      @(negedge hb_clk); #1;
      if (ren) begin
        check("idle_raddr", {30'b0, raddr}, 32'd1);
        check("poll_period", cyc - prev, 32'd6);
        prev = cyc;
      end
    end
    check("idle_tx_drained", {31'b0, tx_drained}, 32'd1);
    check("idle_no_writes", n_wr, 32'd0);

    // Test 2: one RX byte, latency from its poll
    @(posedge hb_clk); #1;
    stat = 4'b0011;
    rx_ready = 1'b1;
    rxq.push_back(8'hA5);
    exp_rx.push_back(8'hA5);
    wait_ev(1, "rx_read_issued");
    check("rx_read_after_poll", cyc - last_poll, 32'd2);
    p = last_poll;
    idle(1);
    check("rx_valid_in_rd_wait", {31'b0, rx_valid}, 32'd0);
    idle(1);
    check("rx_valid_4_after_poll", {31'b0, rx_valid}, 32'd1);
    check("rx_data_a5", {24'b0, rx_data}, 32'hA5);
    check("rx_latency", cyc - p, 32'd4);

    // Test 3: single TX byte, one write only
    @(posedge hb_clk); #1;
    stat = 4'b0001;
    w0 = n_wr;
    exp_tx.push_back(8'h3C);
    tx_src.push_back(8'h3C);
    wait_ev(2, "tx_write_issued");
    check("tx_write_after_poll", cyc - last_poll, 32'd2);
    idle(20);
    check("tx_single_write", n_wr - w0, 32'd1);
    check("tx_valid_dropped", {31'b0, tx_valid}, 32'd0);

    // Test 4: RX and TX both pending -> accesses alternate
    @(posedge hb_clk); #1;
    stat = 4'b0000;
    rx_ready = 1'b1;
    log_en = 1'b1;
    foreach (exp_seq[i]) begin
      if (i < 3) begin
        rxq.push_back(8'h11 * (i + 1));
        exp_rx.push_back(8'h11 * (i + 1));
        tx_src.push_back(8'h44 + 8'h11 * i);
        exp_tx.push_back(8'h44 + 8'h11 * i);
      end
    end
    repeat (3) @(posedge hb_clk);
    #1;
    stat = 4'b0011;
    idle(80);
    log_en = 1'b0;
    check("alt_access_count", acc_log.size(), 32'd6);
    foreach (exp_seq[i]) begin
      if (i < acc_log.size()) check($sformatf("alt_access_%0d", i), {24'b0, acc_log[i]}, {24'b0, exp_seq[i]});
    end

    // Test 5: back-pressure holds the byte and blocks further RX reads
    @(posedge hb_clk); #1;
    rx_ready = 1'b0;
    rxq.push_back(8'h77);
    rxq.push_back(8'h88);
    exp_rx.push_back(8'h77);
    exp_rx.push_back(8'h88);
    wait_ev(3, "bp_rx_valid");
    r0 = n_rd;
    for (int i = 0; i < 20; i++) begin
      @(negedge hb_clk); #1;
      if (i % 5 == 0) begin
        check("bp_rx_data_held", {24'b0, rx_data}, 32'h77);
        check("bp_rx_valid_held", {31'b0, rx_valid}, 32'd1);
      end
    end
    check("bp_no_read", n_rd - r0, 32'd0);
    @(posedge hb_clk); #1;
    rx_ready = 1'b1;
    idle(20);
    check("bp_next_read", n_rd - r0, 32'd1);

    // Test 6a: reset during RD_RX aborts the access
    rxq.push_back(8'hAA);
    wait_ev(1, "abort_read_issued");
    rst = 1'b1;
    idle(1);
    check("abort_ren", {31'b0, ren}, 32'd0);
    check("abort_wen", {31'b0, wen}, 32'd0);
    check("abort_rx_valid", {31'b0, rx_valid}, 32'd0);
    rst = 1'b0;
    idle(1);
    check("abort_repoll_ren", {31'b0, ren}, 32'd1);
    check("abort_repoll_raddr", {30'b0, raddr}, 32'd1);
    idle(1);
    check("abort_status_ren", {31'b0, ren}, 32'd0);

    // Test 6b: reset discards a held byte
    @(posedge hb_clk); #1;
    rx_ready = 1'b0;
    rxq.push_back(8'hBB);
    wait_ev(3, "held_rx_valid");
    check("held_rx_data", {24'b0, rx_data}, 32'hBB);
    rst = 1'b1;
    idle(1);
    check("discard_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("discard_rx_data", {24'b0, rx_data}, 32'd0);
    rst = 1'b0;
    idle(20);

    check("rx_scoreboard_drained", exp_rx.size(), 32'd0);
    check("tx_scoreboard_drained", exp_tx.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
